// File: rtl/pos_fetch_ctrl.sv
// Per-frame fetch of six position words into a shadow set, committed to the
// outputs in one edge once the last word has returned from memory.
module pos_fetch_ctrl #(
  parameter int WIDTH = 16,
  parameter int MXP   = 6000,
  parameter int MYP   = 6004,
  parameter int P1XP  = 6008,
  parameter int P1YP  = 6012,
  parameter int P2XP  = 6016,
  parameter int P2YP  = 6020
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             vblank_start,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic [WIDTH-1:0] mx,
  output logic [WIDTH-1:0] my,
  output logic [WIDTH-1:0] p1x,
  output logic [WIDTH-1:0] p1y,
  output logic [WIDTH-1:0] p2x,
  output logic [WIDTH-1:0] p2y,
  output logic             snap_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_e;
  localparam logic [2:0] LAST_IDX = 3'd5;

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       rd_idx_q;
  logic             rd_valid_q;
  logic             mem_rd_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic             snap_valid_q;
  logic             overrun_q;
  logic [WIDTH-1:0] shadow_q [6];
  logic [WIDTH-1:0] snap_q   [6];

  function automatic logic [WIDTH-1:0] addr_of(input logic [2:0] i);
    case (i)
      3'd0:    addr_of = WIDTH'(MXP);
      3'd1:    addr_of = WIDTH'(MYP);
      3'd2:    addr_of = WIDTH'(P1XP);
      3'd3:    addr_of = WIDTH'(P1YP);
      3'd4:    addr_of = WIDTH'(P2XP);
      3'd5:    addr_of = WIDTH'(P2YP);
      default: addr_of = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rd_idx_q     <= '0;
      rd_valid_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      snap_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        snap_q[i]   <= '0;
      end
    end else begin
      // Read data trails its address by one cycle, so the tag follows mem_rd.
      rd_valid_q   <= mem_rd_q;
      rd_idx_q     <= idx_q;
      snap_valid_q <= 1'b0;
      if (rd_valid_q && rd_idx_q <= LAST_IDX) shadow_q[rd_idx_q] <= mem_data;
      if (vblank_start && state_q != IDLE) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (vblank_start && en) begin
            state_q    <= FETCH;
            idx_q      <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addr_of(3'd0);
          end
        end
        FETCH: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= DRAIN;
            idx_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
          end else begin
            idx_q      <= idx_q + 3'd1;
            mem_addr_q <= addr_of(idx_q + 3'd1);
          end
        end
        DRAIN: state_q <= COMMIT;
        COMMIT: begin
          for (int i = 0; i < 6; i++) snap_q[i] <= shadow_q[i];
          snap_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign mx         = snap_q[0];
  assign my         = snap_q[1];
  assign p1x        = snap_q[2];
  assign p1y        = snap_q[3];
  assign p2x        = snap_q[4];
  assign p2y        = snap_q[5];
  assign snap_valid = snap_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pos_fetch_ctrl.sv
// Scoreboard bench for pos_fetch_ctrl: requests push expected snapshots and
// fetch addresses; a monitor pops and compares whenever the DUT presents them.
module tb_pos_fetch_ctrl;
  localparam int W     = 16;
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         vblank_start = 1'b0;
  logic [W-1:0] mem_addr;
  logic         mem_rd;
  logic [W-1:0] mem_data = '0;
  logic [W-1:0] mx, my, p1x, p1y, p2x, p2y;
  logic         snap_valid, busy, overrun;

  pos_fetch_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .vblank_start(vblank_start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
    .snap_valid(snap_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0][W-1:0] v; int e; } snap_t;
  typedef struct { logic [W-1:0] a; int e; } rd_t;

  snap_t             snap_q[$];
  rd_t               rd_q[$];
  logic [5:0][W-1:0] words;
  logic [5:0][W-1:0] cur_exp = '0;
  logic [W-1:0]      pend_addr = '0;
  int edge_n   = 0;
  int total    = 0;
  int bad      = 0;
  int last_e0  = 0;
  int ovr_edge = NEVER;
  bit have_seq = 1'b0;

  always @(posedge clk) edge_n++;

  // Memory port A: address sampled mid-cycle, data returned one cycle later.
  function automatic logic [W-1:0] lookup(input logic [W-1:0] a);
    for (int k = 0; k < 6; k++)
      if (a == W'(6000 + 4 * k)) return words[k];
    return 16'hDEAD;
  endfunction
  always @(negedge clk) pend_addr = mem_addr;
  always @(posedge clk) begin
    #1;
    mem_data = lookup(pend_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  function automatic bit busy_exp();
    return have_seq && edge_n >= last_e0 && edge_n <= last_e0 + 7;
  endfunction

  function automatic bit mem_safe();
    return !have_seq || edge_n >= last_e0 + 6;
  endfunction

  initial begin : monitor
    snap_t s;
    rd_t   r;
    forever begin
      @(negedge clk);
      #1;
      chk("busy", 32'(busy), 32'(busy_exp()));
      chk("overrun", 32'(overrun), 32'(edge_n >= ovr_edge));
      if (snap_valid) begin
        if (snap_q.size() == 0) begin
          chk("snap_unexpected", 32'(snap_valid), 32'(0));
        end else begin
          s = snap_q.pop_front();
          chk("snap_edge", edge_n, s.e);
          cur_exp = s.v;
        end
      end else if (snap_q.size() > 0 && snap_q[0].e <= edge_n) begin
        s = snap_q.pop_front();
        chk("snap_missing", 32'(snap_valid), 32'(1));
      end
      chk("mx",  32'(mx),  32'(cur_exp[0]));
      chk("my",  32'(my),  32'(cur_exp[1]));
      chk("p1x", 32'(p1x), 32'(cur_exp[2]));
      chk("p1y", 32'(p1y), 32'(cur_exp[3]));
      chk("p2x", 32'(p2x), 32'(cur_exp[4]));
      chk("p2y", 32'(p2y), 32'(cur_exp[5]));
      if (mem_rd) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", 32'(mem_rd), 32'(0));
        end else begin
          r = rd_q.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(r.a));
          chk("rd_edge", edge_n, r.e);
        end
      end else begin
        chk("addr_idle", 32'(mem_addr), 32'(0));
        if (rd_q.size() > 0 && rd_q[0].e <= edge_n) begin
          r = rd_q.pop_front();
          chk("rd_missing", 32'(mem_rd), 32'(1));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a request sampled at edge e is accepted when idle and enabled;
  // it occupies edges e..e+8, reads word k at edge e+k, commits at e+8.
  task automatic pulse(input bit en_v);
    int    e;
    snap_t s;
    rd_t   r;
    @(negedge clk);
    e = edge_n + 1;
    if (have_seq && e > last_e0 && e <= last_e0 + 8) begin
      if (e < ovr_edge) ovr_edge = e;
    end else if (en_v) begin
      have_seq = 1'b1;
      last_e0  = e;
      s.v = words;
      s.e = e + 8;
      snap_q.push_back(s);
      for (int k = 0; k < 6; k++) begin
        r.a = W'(6000 + 4 * k);
        r.e = e + k;
        rd_q.push_back(r);
      end
    end
    vblank_start = 1'b1;
    en = en_v;
    @(negedge clk);
    vblank_start = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    reset = 1'b0;
    vblank_start = 1'b0;
    snap_q.delete();
    rd_q.delete();
    cur_exp  = '0;
    have_seq = 1'b0;
    ovr_edge = NEVER;
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_words(input logic [W-1:0] base, input logic [W-1:0] step);
    for (int k = 0; k < 6; k++) words[k] = base + W'(k) * step;
  endtask

  initial begin : stim
    set_words(16'h0010, 16'h0010);
    idle(3);
    reset = 1'b1;

    // Basic fetch and commit, 0x0010..0x0060.
    pulse(1'b1);
    idle(10);

    // Requests exactly nine edges apart are all accepted.
    set_words(16'h0100, 16'h0001);
    pulse(1'b1);
    idle(7);
    set_words(16'h0200, 16'h0003);
    pulse(1'b1);
    idle(7);
    pulse(1'b1);
    idle(10);

    // Disabled request is ignored.
    set_words(16'hBEEF, 16'h0000);
    pulse(1'b0);
    idle(10);

    // Second request during FETCH, memory changed once reads are done.
    set_words(16'h0010, 16'h0010);
    pulse(1'b1);
    idle(1);
    pulse(1'b1);
    idle(3);
    set_words(16'h1111, 16'h0000);
    idle(6);
    pulse(1'b1);
    idle(10);

    // Request coinciding with COMMIT.
    set_words(16'h0010, 16'h0010);
    pulse(1'b1);
    idle(6);
    pulse(1'b1);
    idle(10);

    // Reset during FETCH at idx 3 after a committed snapshot.
    do_reset(2);
    pulse(1'b1);
    idle(10);
    set_words(16'h7777, 16'h0001);
    pulse(1'b1);
    idle(2);
    do_reset(3);
    idle(12);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      idle($urandom_range(0, 12));
      if (mem_safe() && ($urandom_range(0, 2) == 0))
        for (int k = 0; k < 6; k++) words[k] = W'($urandom);
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
      else pulse($urandom_range(0, 3) != 0);
      en = 1'($urandom_range(0, 1));
    end

    idle(15);
    chk("snap_left", snap_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
